// File: rtl/console_pkg.sv
// rtl/console_pkg.sv - shared character constants and output FSM state type for console_tx
package console_pkg;
  localparam logic [7:0] EOT_CHAR = 8'h04;
  localparam logic [7:0] LF_CHAR  = 8'h0A;
  localparam logic [7:0] CR_CHAR  = 8'h0D;

  typedef enum logic {
    S_DATA = 1'b0,
    S_LF   = 1'b1
  } tx_state_t;
endpackage

// File: rtl/console_fifo.sv
// rtl/console_fifo.sv - byte FIFO with show-ahead head and extra-bit pointers for full/empty
module console_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [7:0]  mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Same index with differing wrap bits means the writer is a full lap ahead.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign head  = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/console_tx.sv
// rtl/console_tx.sv - CPU console output: FIFO, EOT/done tracking, sent counter; CONSOLE_CRLF_EN inserts CR before LF
module console_tx
  import console_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  output logic             wr_full,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  input  logic             tx_ready,
  output logic             overflow,
  output logic             done,
  output logic [CNT_W-1:0] sent_cnt
);
`ifdef CONSOLE_CRLF_EN
  localparam logic CRLF = 1'b1;
`else
  localparam logic CRLF = 1'b0;
`endif

  tx_state_t  state;
  logic       eot_pending;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] head;
  logic       is_eot;
  logic       push;
  logic       pop;
  logic       hs;
  logic       cr_insert;

  assign is_eot    = (wr_data == EOT_CHAR);
  assign push      = wr_en && !fifo_full && !done && !is_eot;
  assign hs        = tx_valid && tx_ready;
  assign cr_insert = CRLF && (state == S_DATA) && !fifo_empty && (head == LF_CHAR);
  // An LF head stays queued through its CR handshake and is only popped from S_LF.
  assign pop       = hs && !cr_insert;

  console_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (wr_data),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign wr_full  = fifo_full;
  assign tx_valid = !fifo_empty;

  always_comb begin
    tx_data = head;
    if (state == S_LF)  tx_data = LF_CHAR;
    else if (cr_insert) tx_data = CR_CHAR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_DATA;
      eot_pending <= 1'b0;
      overflow    <= 1'b0;
      done        <= 1'b0;
      sent_cnt    <= '0;
    end else begin
      if (wr_en && !done && is_eot)                eot_pending <= 1'b1;
      if (wr_en && !done && !is_eot && fifo_full)  overflow    <= 1'b1;
      if (eot_pending && fifo_empty && state == S_DATA) done   <= 1'b1;
      if (hs) sent_cnt <= sent_cnt + CNT_W'(1);
      case (state)
        S_DATA: if (hs && cr_insert) state <= S_LF;
        S_LF:   if (hs)              state <= S_DATA;
        default:                     state <= S_DATA;
      endcase
    end
  end
endmodule

// File: tb/tb_console_tx.sv
// tb/tb_console_tx.sv - randomized and directed checks of console_tx against a queue-based model
module tb_console_tx;
  localparam int DEPTH = 8;
  localparam int CNT_W = 16;
`ifdef CONSOLE_CRLF_EN
  localparam bit CRLF = 1'b1;
`else
  localparam bit CRLF = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wr_en = 1'b0;
  logic [7:0]       wr_data = 8'h00;
  logic             wr_full;
  logic             tx_valid;
  logic [7:0]       tx_data;
  logic             tx_ready = 1'b0;
  logic             overflow;
  logic             done;
  logic [CNT_W-1:0] sent_cnt;

  console_tx #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .overflow(overflow), .done(done), .sent_cnt(sent_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: queued characters plus "CR already emitted for head LF"
  logic [7:0]  m_q[$];
  bit          m_cr, m_eot, m_ovf, m_done;
  int unsigned m_cnt;
  logic [7:0]  dut_out[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_cr = 0; m_eot = 0; m_ovf = 0; m_done = 0; m_cnt = 0;
  endtask

  task automatic model_update(input bit we, input logic [7:0] wd, input bit rdy);
    int n;
    bit hs, acc, done_nx;
    n       = m_q.size();
    hs      = (n > 0) && rdy;
    acc     = we && (n < DEPTH) && !m_done && (wd != 8'h04);
    done_nx = m_done || (m_eot && n == 0);
    if (we && !m_done && wd == 8'h04) m_eot = 1;
    if (we && !m_done && wd != 8'h04 && n == DEPTH) m_ovf = 1;
    if (hs) begin
      m_cnt++;
      if (CRLF && m_q[0] == 8'h0A && !m_cr) m_cr = 1;
      else begin
        void'(m_q.pop_front());
        m_cr = 0;
      end
    end
    if (acc) m_q.push_back(wd);
    m_done = done_nx;
  endtask

  task automatic compare_all();
    logic [7:0] exp_data;
    check_eq("tx_valid", {31'b0, tx_valid}, {31'b0, m_q.size() > 0});
    if (m_q.size() > 0) begin
      exp_data = m_q[0];
      if (CRLF && m_q[0] == 8'h0A && !m_cr) exp_data = 8'h0D;
      check_eq("tx_data", {24'b0, tx_data}, {24'b0, exp_data});
    end
    check_eq("wr_full",  {31'b0, wr_full},  {31'b0, m_q.size() == DEPTH});
    check_eq("overflow", {31'b0, overflow}, {31'b0, m_ovf});
    check_eq("done",     {31'b0, done},     {31'b0, m_done});
    check_eq("sent_cnt", {16'b0, sent_cnt}, {16'b0, m_cnt[15:0]});
  endtask

  // one clock: drive, sample mid-cycle, advance model at the edge
  task automatic step(input bit we, input logic [7:0] wd, input bit rdy);
    wr_en = we; wr_data = wd; tx_ready = rdy;
    @(negedge clk);
    compare_all();
    if (tx_valid && tx_ready) dut_out.push_back(tx_data);
    @(posedge clk);
    model_update(we, wd, rdy);
    #1;
  endtask

  task automatic do_reset();
    wr_en = 0; wr_data = 8'h00; tx_ready = 0;
    rst_n = 0;
    #1;
    check_eq("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    check_eq("rst_tx_data",  {24'b0, tx_data},  32'd0);
    check_eq("rst_wr_full",  {31'b0, wr_full},  32'd0);
    check_eq("rst_overflow", {31'b0, overflow}, 32'd0);
    check_eq("rst_done",     {31'b0, done},     32'd0);
    check_eq("rst_sent_cnt", {16'b0, sent_cnt}, 32'd0);
    model_clear();
    dut_out.delete();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 8'h00, rdy);
  endtask

  initial begin
    logic [7:0] d;
    int found;

    // "Hi" with sink always ready
    do_reset();
    step(1, 8'h48, 1);
    step(1, 8'h69, 1);
    idle(3, 1);
    check_eq("hi_count", dut_out.size(), 32'd2);
    if (dut_out.size() == 2) begin
      check_eq("hi_byte0", {24'b0, dut_out[0]}, 32'h48);
      check_eq("hi_byte1", {24'b0, dut_out[1]}, 32'h69);
    end
    check_eq("hi_sent_cnt", {16'b0, sent_cnt}, 32'd2);

    // nine writes into a stalled sink
    do_reset();
    for (int i = 0; i < 9; i++) step(1, 8'h20 + 8'(i), 0);
    check_eq("fill_wr_full", {31'b0, wr_full}, 32'd1);
    check_eq("fill_overflow", {31'b0, overflow}, 32'd1);
    idle(12, 1);
    check_eq("fill_drain_count", dut_out.size(), 32'd8);
    for (int i = 0; i < dut_out.size() && i < 8; i++)
      check_eq("fill_drain_byte", {24'b0, dut_out[i]}, 32'h20 + i);

    // EOT behind a pending byte, then a late write is ignored
    do_reset();
    step(1, 8'h41, 0);
    step(1, 8'h04, 0);
    idle(5, 0);
    check_eq("eot_done_stalled", {31'b0, done}, 32'd0);
    step(0, 8'h00, 1);
    idle(2, 1);
    check_eq("eot_done_after", {31'b0, done}, 32'd1);
    step(1, 8'h42, 1);
    idle(3, 1);
    check_eq("eot_late_valid", {31'b0, tx_valid}, 32'd0);
    check_eq("eot_out_count", dut_out.size(), 32'd1);
    check_eq("eot_overflow", {31'b0, overflow}, 32'd0);

    // LF expansion
    do_reset();
    step(1, 8'h0A, 1);
    idle(4, 1);
    if (CRLF) begin
      check_eq("lf_count", dut_out.size(), 32'd2);
      if (dut_out.size() == 2) begin
        check_eq("lf_byte0", {24'b0, dut_out[0]}, 32'h0D);
        check_eq("lf_byte1", {24'b0, dut_out[1]}, 32'h0A);
      end
      check_eq("lf_sent_cnt", {16'b0, sent_cnt}, 32'd2);
    end else begin
      check_eq("lf_count", dut_out.size(), 32'd1);
      if (dut_out.size() == 1) check_eq("lf_byte0", {24'b0, dut_out[0]}, 32'h0A);
      check_eq("lf_sent_cnt", {16'b0, sent_cnt}, 32'd1);
    end

    // reset while four bytes are queued and an LF follows its CR
    do_reset();
    step(1, 8'h0A, 0);
    step(1, 8'h31, 0);
    step(1, 8'h32, 0);
    step(1, 8'h33, 0);
    if (CRLF) step(0, 8'h00, 1);
    do_reset();
    idle(6, 1);
    check_eq("rst_mid_out_count", dut_out.size(), 32'd0);
    check_eq("rst_mid_valid", {31'b0, tx_valid}, 32'd0);

    // write while full with a simultaneous pop is still rejected
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1, 8'h10 + 8'(i), 0);
    step(1, 8'h55, 1);
    check_eq("fullpop_overflow", {31'b0, overflow}, 32'd1);
    check_eq("fullpop_wr_full", {31'b0, wr_full}, 32'd0);
    idle(12, 1);
    check_eq("fullpop_count", dut_out.size(), 32'd8);
    found = 0;
    foreach (dut_out[i]) if (dut_out[i] == 8'h55) found++;
    check_eq("fullpop_no_55", found, 32'd0);

    // randomized segments
    for (int seg = 0; seg < 8; seg++) begin
      do_reset();
      for (int c = 0; c < 300; c++) begin
        case ($urandom_range(0, 99))
          0:       d = 8'h04;
          1,2,3,4,5,6,7,8,9,10: d = 8'h0A;
          default: d = 8'($urandom);
        endcase
        step($urandom_range(0, 1) == 1, d, $urandom_range(0, 3) != 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
